// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction memory request/response bus between the fetch stage and imem.
interface fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold, and an
// unstalled cycle without a load retires the current instruction.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   flush_i,
  input  logic   stall_i,
  input  if_id_t data_i,
  output if_id_t data_o,
  output logic   valid_o
);

  if_id_t data_q;
  logic   valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0};
      valid_q <= 1'b0;
    end else if (flush_i) begin
      data_q.instr <= NOP_INSTR;
      valid_q      <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (!stall_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Single-outstanding instruction fetch with skid buffer and redirect kill.
// Optional macro FETCH_STATS_EN adds fetch_count_o (instructions loaded into IF/ID).
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  fetch_if.master     imem,
  output logic [31:0] instr_d_o,
  output logic [31:0] pc_d_o,
  output logic [31:0] pc_plus4_d_o,
  output logic        valid_d_o
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count_o
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  skid_q, skid_d;
  logic         kill_q, kill_d;
  logic         req, load, flush;
  logic [31:0]  load_instr;
  if_id_t       ifid_in, ifid_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      skid_q  <= NOP_INSTR;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    kill_d     = kill_q;
    req        = 1'b0;
    load       = 1'b0;
    flush      = 1'b0;
    load_instr = imem.imem_rdata_i;
    if (redirect_i) begin
      flush   = 1'b1;
      pc_d    = align_pc(redirect_pc_i);
      state_d = IDLE;
      kill_d  = 1'b0;
      // The in-flight request cannot be cancelled, so remember to drop its response.
      if (state_q == WAIT && !imem.imem_rvalid_i) begin
        state_d = WAIT;
        kill_d  = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          req     = 1'b1;
          state_d = WAIT;
        end
        WAIT: begin
          if (imem.imem_rvalid_i) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = IDLE;
            end else if (!valid_d_o || !stall_i) begin
              load    = 1'b1;
              pc_d    = pc_q + 32'd4;
              state_d = IDLE;
            end else begin
              skid_d  = imem.imem_rdata_i;
              state_d = FULL;
            end
          end
        end
        FULL: begin
          if (!stall_i) begin
            load       = 1'b1;
            load_instr = skid_q;
            pc_d       = pc_q + 32'd4;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign imem.imem_req_o  = req && !rst;
  assign imem.imem_addr_o = pc_q;

  assign ifid_in = '{instr: load_instr, pc: pc_q, pc_plus4: pc_q + 32'd4};

  if_id_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .flush_i (flush),
    .stall_i (stall_i),
    .data_i  (ifid_in),
    .data_o  (ifid_out),
    .valid_o (valid_d_o)
  );

  assign instr_d_o    = ifid_out.instr;
  assign pc_d_o       = ifid_out.pc;
  assign pc_plus4_d_o = ifid_out.pc_plus4;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk) begin
    if (rst) fetch_count_q <= 32'h0;
    else if (load) fetch_count_q <= fetch_count_q + 32'd1;
  end

  assign fetch_count_o = fetch_count_q;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 stall_i  input  1  SHALL mean decode cannot accept a new instruction; hold IF/ID.
REQ-005 redirect_i  input  1  SHALL mean a taken branch or jump from execute.
REQ-006 redirect_pc_i  input  32  SHALL carry the redirect target.
REQ-007 imem_req_o  output  1  SHALL be a one-cycle fetch request strobe.
REQ-008 imem_addr_o  output  32  SHALL carry the fetch address, valid while imem_req_o=1.
REQ-009 imem_rvalid_i  input  1  SHALL mark the response cycle, 1 or more cycles after the request.
REQ-010 imem_rdata_i  input  32  SHALL carry the instruction word, valid with imem_rvalid_i.
REQ-011 instr_d_o, pc_d_o, pc_plus4_d_o  output  32 each  SHALL be the IF/ID register; decode slices instr_d_o[31:7] for immediate extension.
REQ-012 valid_d_o  output  1  SHALL mark IF/ID contents as a live instruction.

Function
REQ-013 FSM states SHALL be IDLE (issue), WAIT (one request outstanding), FULL (response parked in skid register); at most one request outstanding.
REQ-014 IDLE: imem_req_o=1 and imem_addr_o=pc_q unless redirect_i=1; next state WAIT.
REQ-015 WAIT: with rvalid and kill_q=0, if !valid_d_o or !stall_i, load IF/ID ({rdata, pc_q, pc_q+4}, valid_d_o=1), set pc_q=pc_q+4, go IDLE; otherwise capture into skid and go FULL.
REQ-016 WAIT: with rvalid and kill_q=1, discard the response, clear kill_q, go IDLE.
REQ-017 FULL: when !stall_i, move skid into IF/ID, set pc_q=pc_q+4, go IDLE.
REQ-018 When valid_d_o=1, stall_i=0 and no load occurs, valid_d_o SHALL clear next cycle.
REQ-019 stall_i=1 SHALL hold all IF/ID outputs unchanged.
REQ-020 redirect_i SHALL take priority over every other event: pc_q=redirect_pc_i with bits [1:0] forced to 00, valid_d_o=0, instr_d_o=NOP, skid discarded.
REQ-021 Redirect in WAIT without rvalid SHALL set kill_q and stay in WAIT; redirect coinciding with rvalid SHALL discard the response and go IDLE; redirect in IDLE or FULL SHALL go IDLE.
REQ-022 Best-case throughput SHALL be one instruction per 2 cycles; request-to-IF/ID latency SHALL be response latency +1.
REQ-023 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

Reset
REQ-024 rst SHALL set state=IDLE, pc_q=RESET_PC, kill_q=0, valid_d_o=0, instr_d_o=NOP (32'h0000_0013), pc_d_o=0, pc_plus4_d_o=0, imem_req_o=0 during the reset cycle.
REQ-025 Reset with a request outstanding SHALL clear state; any later stray rvalid in IDLE SHALL be ignored.

Configuration
REQ-026 Macro FETCH_STATS_EN defined: output fetch_count_o [31:0] SHALL count instructions loaded into IF/ID (killed responses excluded), reset to 0, wrap at 2^32.
REQ-027 FETCH_STATS_EN undefined: port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package fetch_pkg SHALL hold fetch_state_t (IDLE/WAIT/FULL), NOP_INSTR and the IF/ID struct type.
REQ-029 Sub-module if_id_reg SHALL implement the IF/ID register with load/hold/flush controls; FSM, PC and skid stay in fetch_stage.

Verification
REQ-030 Reset, RESET_PC=0, 1-cycle memory returning 0x00500093, 0x00A00113 -> imem_addr_o 0x0, 0x4; IF/ID valid on cycles 2 and 4 with pc_d_o 0x0, 0x4.
REQ-031 stall_i held 3 cycles while response arrives -> skid holds word, state FULL, no new request; on release IF/ID loads it, next request at pc+4.
REQ-032 redirect_i with redirect_pc_i=0x0000_0103 while WAIT, response 2 cycles later -> response dropped, valid_d_o=0, next imem_addr_o=0x0000_0100.
REQ-033 redirect_i and imem_rvalid_i in the same cycle -> response dropped, IF/ID flushed to NOP, next request to redirect target.
REQ-034 pc_q=0xFFFF_FFFC fetch -> pc_plus4_d_o=0x0, next imem_addr_o=0x0.
REQ-035 FETCH_STATS_EN defined, 5 fetches with one killed -> fetch_count_o=4; rst mid-WAIT -> fetch_count_o=0, state IDLE, stray rvalid ignored.
